d_cache_wb: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, tree pseudo-LRU replacement and an uncached bypass window. It sits between the MIPS core's sram-like data port and the sram-like port of the AXI bridge. It is the successor to the 2-way, 1-word, write-through data cache.

---
 rtl/d_cache_wb_pkg.sv | 23 ++
 rtl/d_cache_plru.sv | 23 ++
 rtl/d_cache_wb.sv | 167 ++++++++++++++++
 tb/tb_d_cache_wb.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_wb_pkg.sv
// d_cache_wb_pkg: shared FSM encoding, uncached segment and byte-lane helpers for the cache successors
package d_cache_wb_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RF   = 2'd2,
    S_UNC  = 2'd3
  } state_e;

  localparam logic [2:0] UNC_SEG = 3'b101;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    byte_mask = (size == 2'd0) ? 4'b0001 << off :
                (size == 2'd1) ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/d_cache_plru.sv
// d_cache_plru: tree pseudo-LRU next-state and victim selection for one set
module d_cache_plru #(
  parameter int WAYS = 2,
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PW-1:0] tree_i,
  input  logic [WW-1:0] way_i,
  output logic [PW-1:0] tree_o,
  output logic [WW-1:0] victim_o
);
  // tree bits point toward the less recently used side: [0] root, [1] ways 0/1, [2] ways 2/3
  if (WAYS == 4) begin : g4
    assign tree_o   = way_i[1] ? {~way_i[0], tree_i[1], 1'b0} : {tree_i[2], ~way_i[0], 1'b1};
    assign victim_o = tree_i[0] ? {1'b1, tree_i[2]} : {1'b0, tree_i[1]};
  end else if (WAYS == 2) begin : g2
    assign tree_o   = ~way_i;
    assign victim_o = tree_i;
  end else begin : g1
    assign tree_o   = tree_i | PW'(way_i & 1'b0);
    assign victim_o = '0;
  end
endmodule

// File: rtl/d_cache_wb.sv
// d_cache_wb: N-way write-back write-allocate data cache with PLRU and kseg1 bypass
module d_cache_wb
  import d_cache_wb_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);
  localparam int IW    = INDEX_WIDTH;
  localparam int OW    = OFFSET_WIDTH;
  localparam int SETS  = 1 << IW;
  localparam int WORDS = 1 << (OW - 2);
  localparam int TW    = 32 - IW - OW;
  localparam int CW    = (OW > 2) ? OW - 2 : 1;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            issued_q;
  logic [WW-1:0]   vway_q;
  logic [TW-1:0]   vtag_q, rtag_q;
  logic [IW-1:0]   ridx_q;
  logic            unc_wr_q;
  logic [1:0]      unc_size_q;
  logic [31:0]     unc_addr_q, unc_wdata_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [PW-1:0]   plru_q  [SETS];
  logic [TW-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]     data_q  [WAYS][SETS][WORDS];

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [CW-1:0] wsel;
  logic          uncached, hit, has_inv, hit_acc, busy, is_unc, addr_hs, last;
  logic [WW-1:0] hit_way, inv_way, plru_victim, victim;
  logic [PW-1:0] plru_d;

  assign tag      = cpu_data_addr[31 -: TW];
  assign idx      = cpu_data_addr[OW +: IW];
  assign wsel     = CW'(cpu_data_addr >> 2) & CW'(WORDS - 1);
  assign uncached = cpu_data_addr[31:29] == UNC_SEG;

  // lowest-numbered invalid way wins because the scan runs downward
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  d_cache_plru #(.WAYS(WAYS)) u_plru (
    .tree_i  (plru_q[idx]),
    .way_i   (hit_way),
    .tree_o  (plru_d),
    .victim_o(plru_victim)
  );

  assign victim  = has_inv ? inv_way : plru_victim;
  assign hit_acc = !rst && state_q == S_IDLE && cpu_data_req && !uncached && hit;
  assign busy    = !rst && state_q != S_IDLE;
  assign is_unc  = state_q == S_UNC;
  assign last    = cnt_q == CW'(WORDS - 1);
  assign addr_hs = cache_data_req && cache_data_addr_ok;

  assign cpu_data_addr_ok = hit_acc || (busy && is_unc && cache_data_addr_ok);
  assign cpu_data_data_ok = hit_acc || (busy && is_unc && cache_data_data_ok);
  assign cpu_data_rdata   = (busy && is_unc) ? cache_data_rdata :
                            hit_acc ? data_q[hit_way][idx][wsel] : '0;

  // the core holds its request until addr_ok, so the latched copy is only needed afterwards
  assign cache_data_req   = busy && !issued_q;
  assign cache_data_wr    = busy && (is_unc ? (issued_q ? unc_wr_q : cpu_data_wr) : state_q == S_WB);
  assign cache_data_size  = !busy ? 2'd0 : is_unc ? (issued_q ? unc_size_q : cpu_data_size) : 2'd2;
  assign cache_data_addr  = !busy ? '0 : is_unc ? (issued_q ? unc_addr_q : cpu_data_addr) :
                            (32'({(state_q == S_WB) ? vtag_q : rtag_q, ridx_q}) << OW) | (32'(cnt_q) << 2);
  assign cache_data_wdata = !busy ? '0 : is_unc ? (issued_q ? unc_wdata_q : cpu_data_wdata) :
                            (state_q == S_WB) ? data_q[vway_q][ridx_q][cnt_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      issued_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (state_q == S_IDLE) begin
      if (cpu_data_req && uncached) begin
        state_q <= S_UNC;
      end else if (cpu_data_req && hit) begin
        plru_q[idx] <= plru_d;
        if (cpu_data_wr) dirty_q[idx][hit_way] <= 1'b1;
      end else if (cpu_data_req) begin
        vway_q                <= victim;
        vtag_q                <= tag_q[victim][idx];
        rtag_q                <= tag;
        ridx_q                <= idx;
        cnt_q                 <= '0;
        issued_q              <= 1'b0;
        valid_q[idx][victim]  <= 1'b0;
        state_q               <= (valid_q[idx][victim] && dirty_q[idx][victim]) ? S_WB : S_RF;
      end
    end else begin
      if (addr_hs && !cache_data_data_ok) issued_q <= 1'b1;
      if (addr_hs && is_unc) begin
        unc_wr_q    <= cpu_data_wr;
        unc_size_q  <= cpu_data_size;
        unc_addr_q  <= cpu_data_addr;
        unc_wdata_q <= cpu_data_wdata;
      end
      if (cache_data_data_ok) begin
        issued_q <= 1'b0;
        cnt_q    <= (last || is_unc) ? '0 : cnt_q + 1'b1;
        if (is_unc) state_q <= S_IDLE;
        else if (last && state_q == S_WB) state_q <= S_RF;
        else if (last) begin
          valid_q[ridx_q][vway_q] <= 1'b1;
          dirty_q[ridx_q][vway_q] <= 1'b0;
          state_q                 <= S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_acc && cpu_data_wr)
      data_q[hit_way][idx][wsel] <= merge_bytes(data_q[hit_way][idx][wsel], cpu_data_wdata,
                                                byte_mask(cpu_data_size, cpu_data_addr[1:0]));
    if (!rst && state_q == S_RF && cache_data_data_ok) begin
      data_q[vway_q][ridx_q][cnt_q] <= cache_data_rdata;
      if (last) tag_q[vway_q][ridx_q] <= rtag_q;
    end
  end
endmodule

// File: tb/tb_d_cache_wb.sv
// tb_d_cache_wb: directed checks of d_cache_wb against a simple sram-like bridge model
module tb_d_cache_wb;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [1:0]  cpu_size = 2'd2;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  int          total = 0, fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic        fast = 1'b0, pend_q = 1'b0;
  logic [31:0] pend_rdata = '0;
  int          n_txn = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_wdata [64];
  logic        log_wr [64];
  logic [1:0]  log_size [64];

  d_cache_wb dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_req), .cpu_data_wr(cpu_wr), .cpu_data_size(cpu_size),
    .cpu_data_addr(cpu_addr), .cpu_data_wdata(cpu_wdata),
    .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok),
    .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
    .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
    .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a ^ 32'hC0DE_0000;
  endfunction

  // bridge: always ready; data_ok either next cycle (split) or with addr_ok (fast)
  assign cache_data_addr_ok = cache_data_req;
  assign cache_data_data_ok = fast ? cache_data_req : pend_q;
  assign cache_data_rdata   = fast ? rd(cache_data_addr) : pend_rdata;

  always @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else if (cache_data_req && cache_data_addr_ok) begin
      if (n_txn < 64) begin
        log_addr[n_txn]  <= cache_data_addr;
        log_wdata[n_txn] <= cache_data_wdata;
        log_wr[n_txn]    <= cache_data_wr;
        log_size[n_txn]  <= cache_data_size;
      end
      n_txn      <= n_txn + 1;
      pend_q     <= !fast;
      pend_rdata <= rd(cache_data_addr);
      if (cache_data_wr) mem[cache_data_addr] = cache_data_wdata;
    end else pend_q <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd_o, output int cyc);
    logic aok, done;
    aok = 1'b0; done = 1'b0; rd_o = '0; cyc = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = wr; cpu_size = sz; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (cpu_data_addr_ok) aok = 1'b1;
      if (cpu_data_data_ok) begin
        done = 1'b1;
        rd_o = cpu_data_rdata;
      end
      @(negedge clk);
      cyc++;
      if (aok) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    chk("cpu_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int c, b;
    mem[32'h40] = 32'h1122_3344;
    mem[32'h44] = 32'h5566_7788;
    mem[32'h48] = 32'h99AA_BBCC;
    mem[32'h4C] = 32'hDDEE_FF00;
    cpu_req = 1'b1; cpu_addr = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(cache_data_req), 32'd0);
    chk("rst_aok", 32'(cpu_data_addr_ok), 32'd0);
    chk("rst_dok", 32'(cpu_data_data_ok), 32'd0);
    chk("rst_addr", cache_data_addr, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // clean miss then hits
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h40, '0, r, c);
    chk("rd40_data", r, 32'h1122_3344);
    chk("rd40_cyc", 32'(c), 32'd10);
    chk("rd40_ntxn", 32'(n_txn - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("rd40_addr", log_addr[b+i], 32'h40 + 32'(4 * i));
      chk("rd40_wr", 32'(log_wr[b+i]), 32'd0);
    end
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h40, '0, r, c);
    chk("hit40_data", r, 32'h1122_3344);
    chk("hit40_cyc", 32'(c), 32'd1);
    cpu(1'b0, 2'd2, 32'h48, '0, r, c);
    chk("hit48_data", r, 32'h99AA_BBCC);
    chk("hit_ntxn", 32'(n_txn - b), 32'd0);

    // partial-width write hits
    cpu(1'b1, 2'd0, 32'h41, 32'hABAB_ABAB, r, c);
    chk("sb_cyc", 32'(c), 32'd1);
    cpu(1'b1, 2'd1, 32'h46, 32'hBEEF_BEEF, r, c);
    cpu(1'b0, 2'd2, 32'h40, '0, r, c);
    chk("sb_data", r, 32'h1122_AB44);
    cpu(1'b0, 2'd2, 32'h44, '0, r, c);
    chk("sh_data", r, 32'hBEEF_7788);
    chk("sb_ntxn", 32'(n_txn - b), 32'd0);
    chk("sb_dirty", 32'(dut.dirty_q[4][0]), 32'd1);

    // fill way 1 of set 4, dirty it, touch way 0, then miss a third tag
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h840, '0, r, c);
    chk("rd840_data", r, 32'hC0DE_0840);
    cpu(1'b1, 2'd2, 32'h84C, 32'h1234_5678, r, c);
    cpu(1'b0, 2'd2, 32'h40, '0, r, c);
    chk("touch0_ntxn", 32'(n_txn - b), 32'd4);
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h1040, '0, r, c);
    chk("ev_data", r, 32'hC0DE_1040);
    chk("ev_cyc", 32'(c), 32'd18);
    chk("ev_ntxn", 32'(n_txn - b), 32'd8);
    chk("ev_wb0_addr", log_addr[b], 32'h840);
    chk("ev_wb0_wr", 32'(log_wr[b]), 32'd1);
    chk("ev_wb1_data", log_wdata[b+1], 32'hC0DE_0844);
    chk("ev_wb3_addr", log_addr[b+3], 32'h84C);
    chk("ev_wb3_data", log_wdata[b+3], 32'h1234_5678);
    chk("ev_rf0_addr", log_addr[b+4], 32'h1040);
    chk("ev_rf0_wr", 32'(log_wr[b+4]), 32'd0);
    chk("ev_rf3_addr", log_addr[b+7], 32'h104C);
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h40, '0, r, c);
    chk("keep0_data", r, 32'h1122_AB44);
    chk("keep0_cyc", 32'(c), 32'd1);
    chk("keep0_ntxn", 32'(n_txn - b), 32'd0);

    // uncached write then read
    b = n_txn;
    cpu(1'b1, 2'd2, 32'hBFC0_0000, 32'hDEAD_BEEF, r, c);
    chk("unc_w_cyc", 32'(c), 32'd3);
    chk("unc_w_ntxn", 32'(n_txn - b), 32'd1);
    chk("unc_w_addr", log_addr[b], 32'hBFC0_0000);
    chk("unc_w_wr", 32'(log_wr[b]), 32'd1);
    chk("unc_w_size", 32'(log_size[b]), 32'd2);
    chk("unc_w_data", log_wdata[b], 32'hDEAD_BEEF);
    b = n_txn;
    cpu(1'b0, 2'd2, 32'hBFC0_0000, '0, r, c);
    chk("unc_r_data", r, 32'hDEAD_BEEF);
    chk("unc_r_ntxn", 32'(n_txn - b), 32'd1);
    chk("unc_r_wr", 32'(log_wr[b]), 32'd0);

    // same-cycle addr_ok/data_ok
    fast = 1'b1;
    b = n_txn;
    cpu(1'b0, 2'd2, 32'h80, '0, r, c);
    chk("fast_data", r, 32'hC0DE_0080);
    chk("fast_cyc", 32'(c), 32'd6);
    chk("fast_ntxn", 32'(n_txn - b), 32'd4);
    chk("fast_addr1", log_addr[b+1], 32'h84);
    chk("fast_addr3", log_addr[b+3], 32'h8C);
    fast = 1'b0;

    // reset during refill at cnt=2
    b = n_txn;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = 32'hC0;
    for (int i = 0; i < 50 && (n_txn - b) < 3; i++) @(negedge clk);
    chk("midrf_reach", 32'(n_txn - b), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrf_req", 32'(cache_data_req), 32'd0);
    chk("midrf_aok", 32'(cpu_data_addr_ok), 32'd0);
    chk("midrf_dok", 32'(cpu_data_data_ok), 32'd0);
    chk("midrf_rdata", cpu_data_rdata, 32'd0);
    chk("midrf_addr", cache_data_addr, 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrf_valid", 32'(dut.valid_q[12]), 32'd0);
    b = n_txn;
    cpu(1'b0, 2'd2, 32'hC0, '0, r, c);
    chk("rerf_data", r, 32'hC0DE_00C0);
    chk("rerf_addr0", log_addr[b], 32'hC0);
    chk("rerf_ntxn", 32'(n_txn - b), 32'd4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
